// File: rtl/div_unit.sv
// div_unit: sequential restoring divider for MIPS div/divu.
// One quotient bit per cycle on operand magnitudes, then one cycle of sign
// correction that loads Hi (remainder) and Lo (quotient).
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Unsigned,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE,
        S_ZERO
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;   // dividend bits shift out the top, quotient bits in at the bottom
    logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // Shifted partial remainder needs one extra bit (divu with a huge
    // divisor), and the trial subtract one more for its sign.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic             trial_ok;
    logic             dvd_neg, dvs_neg;

    assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
    assign trial    = {1'b0, rem_sh} - {2'b00, dvs_q};
    assign trial_ok = ~trial[WIDTH+1];
    assign dvd_neg  = ~Unsigned & Dividend[WIDTH-1];
    assign dvs_neg  = ~Unsigned & Divisor[WIDTH-1];

    assign Hi = hi_q;
    assign Lo = lo_q;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state, datapath update and status outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        Busy    = (state_q != S_IDLE);
        Done    = (state_q == S_DONE) || (state_q == S_ZERO);
        DivZero = (state_q == S_ZERO);

        case (state_q)
            // DONE and ZERO accept a new request too, so the controller can
            // issue back-to-back on the Done cycle.
            S_IDLE, S_DONE, S_ZERO: begin
                state_d = S_IDLE;
                if (Start) begin
                    if (Divisor == '0) begin
                        state_d = S_ZERO;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = CW'(WIDTH - 1);
                        rem_d   = '0;
                        quo_d   = dvd_neg ? -Dividend : Dividend;
                        dvs_d   = dvs_neg ? -Divisor  : Divisor;
                        negq_d  = dvd_neg ^ dvs_neg;
                        negr_d  = dvd_neg;
                    end
                end
            end
            S_RUN: begin
                rem_d = trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], trial_ok};
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FIX: begin
                // 0x80000000 / -1 wraps back to 0x80000000 here by itself.
                lo_d    = negq_q ? -quo_q : quo_q;
                hi_d    = negr_q ? -rem_q : rem_q;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
